branch_resolve_unit: RTL and testbench

Resolves executed branches against their front-end prediction and generates the fetch redirect on a mispredict. Trains the branch predictor through a small update queue. Sits directly downstream of the execute-stage branch unit, consuming its per-instruction result (`taken`, target, prediction). Produces a held redirect request for the fetch stage and a stream of predictor-update entries.

---
 rtl/branch_resolve_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks resolved branches against prediction,
// raises a held fetch redirect on mispredict, queues predictor updates.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   valid_i .. chkp_i         branch-unit result for one instruction
//   flush_i                   pipeline flush from commit
//   stall_o                   update queue full
//   redirect_*                valid/ready redirect to fetch
//   upd_*                     predictor-update queue head, popped by upd_ready_i
//   perf_branches_o,
//   perf_mispred_o            saturating counters, only with BRU_PERF_CNT_EN
//
// Optional feature macro: BRU_PERF_CNT_EN
module branch_resolve_unit #(
  parameter int UPD_DEPTH = 4,
  parameter int CHKP_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [63:0]       pc_i,
  input  logic              is_cond_i,
  input  logic              taken_i,
  input  logic [63:0]       target_i,
  input  logic              ex_valid_i,
  input  logic              pred_taken_i,
  input  logic [63:0]       pred_addr_i,
  input  logic [CHKP_W-1:0] chkp_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [63:0]       redirect_pc_o,
  output logic [CHKP_W-1:0] redirect_chkp_o,
  input  logic              redirect_ready_i,
  output logic              upd_valid_o,
  output logic [63:0]       upd_pc_o,
  output logic [63:0]       upd_target_o,
  output logic              upd_taken_o,
  output logic              upd_cond_o,
  input  logic              upd_ready_i
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches_o,
  output logic [31:0]       perf_mispred_o
`endif
);

  localparam int AW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
    logic        taken;
    logic        cond;
  } upd_t;

  state_t state_q;
  state_t state_d;
  logic   load;

  upd_t          mem [UPD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          accept;
  logic          mispred;
  logic [63:0]   next_pc;
  upd_t          head;
  upd_t          entry;

  assign full  = (count == CW'(UPD_DEPTH));
  assign empty = (count == '0);
  assign pop   = upd_ready_i && !empty;

  // A full queue still takes a push when the head leaves the same cycle.
  assign accept = valid_i && !ex_valid_i && !flush_i &&
                  (state_q == IDLE) && (!full || pop);

  assign mispred = (taken_i != pred_taken_i) ||
                   (taken_i && (target_i != pred_addr_i));

  assign next_pc = taken_i ? target_i : (pc_i + 64'd4);
  assign push    = accept;

  always_comb begin
    entry        = '0;
    entry.pc     = pc_i;
    entry.target = target_i;
    entry.taken  = taken_i;
    entry.cond   = is_cond_i;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && mispred) begin
          state_d = REDIRECT;
          load    = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      redirect_pc_o   <= '0;
      redirect_chkp_o <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        redirect_pc_o   <= next_pc;
        redirect_chkp_o <= chkp_i;
      end
    end
  end

  assign redirect_valid_o = (state_q == REDIRECT);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign stall_o = full;

  // Data outputs read as zero while empty so reset shows clean values.
  assign upd_valid_o  = !empty;
  assign upd_pc_o     = empty ? 64'd0 : head.pc;
  assign upd_target_o = empty ? 64'd0 : head.target;
  assign upd_taken_o  = empty ? 1'b0  : head.taken;
  assign upd_cond_o   = empty ? 1'b0  : head.cond;

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else if (accept) begin
      if (perf_branches_o != 32'hFFFF_FFFF)
        perf_branches_o <= perf_branches_o + 32'd1;
      if (mispred && (perf_mispred_o != 32'hFFFF_FFFF))
        perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(valid_i && stall_o && !upd_ready_i)
  );
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table plus
// hand-written multi-cycle sequences.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [63:0] pc;
  logic        is_cond;
  logic        taken;
  logic [63:0] target;
  logic        ex_valid;
  logic        pred_taken;
  logic [63:0] pred_addr;
  logic [1:0]  chkp;
  logic        flush;
  logic        stall;
  logic        rv;
  logic [63:0] rpc;
  logic [1:0]  rchkp;
  logic        rready;
  logic        uv;
  logic [63:0] upc;
  logic [63:0] utgt;
  logic        utaken;
  logic        ucond;
  logic        uready;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br;
  logic [31:0] perf_mp;
`endif

  int ntests = 0;
  int nfail  = 0;

  branch_resolve_unit #(.UPD_DEPTH(4), .CHKP_W(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_i         (valid),
    .pc_i            (pc),
    .is_cond_i       (is_cond),
    .taken_i         (taken),
    .target_i        (target),
    .ex_valid_i      (ex_valid),
    .pred_taken_i    (pred_taken),
    .pred_addr_i     (pred_addr),
    .chkp_i          (chkp),
    .flush_i         (flush),
    .stall_o         (stall),
    .redirect_valid_o(rv),
    .redirect_pc_o   (rpc),
    .redirect_chkp_o (rchkp),
    .redirect_ready_i(rready),
    .upd_valid_o     (uv),
    .upd_pc_o        (upc),
    .upd_target_o    (utgt),
    .upd_taken_o     (utaken),
    .upd_cond_o      (ucond),
    .upd_ready_i     (uready)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches_o (perf_br),
    .perf_mispred_o  (perf_mp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [63:0] pc;
    logic        cond;
    logic        taken;
    logic [63:0] target;
    logic        exv;
    logic        pt;
    logic [63:0] pa;
    logic [1:0]  chkp;
    logic        flush;
    logic        e_rv;
    logic [63:0] e_rpc;
    logic [1:0]  e_chkp;
    logic        e_uv;
    logic [63:0] e_upc;
    logic [63:0] e_utgt;
    logic        e_utk;
    logic        e_ucond;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(
    input string n, input logic vl, input logic [63:0] p,
    input logic c, input logic tk, input logic [63:0] tg,
    input logic ex, input logic ptk, input logic [63:0] pad,
    input logic [1:0] ck, input logic fl,
    input logic erv, input logic [63:0] erpc, input logic [1:0] eck,
    input logic euv, input logic [63:0] eupc, input logic [63:0] eutg,
    input logic eutk, input logic euc);
    vec_t r;
    r.name = n; r.valid = vl; r.pc = p; r.cond = c; r.taken = tk;
    r.target = tg; r.exv = ex; r.pt = ptk; r.pa = pad; r.chkp = ck;
    r.flush = fl; r.e_rv = erv; r.e_rpc = erpc; r.e_chkp = eck;
    r.e_uv = euv; r.e_upc = eupc; r.e_utgt = eutg;
    r.e_utk = eutk; r.e_ucond = euc;
    return r;
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; pc = '0; is_cond = 0; taken = 0; target = '0;
    ex_valid = 0; pred_taken = 0; pred_addr = '0; chkp = '0;
    flush = 0; rready = 0; uready = 0;
  endtask

  task automatic br(input logic [63:0] p, input logic c,
                    input logic tk, input logic [63:0] tg,
                    input logic ptk, input logic [63:0] pad,
                    input logic [1:0] ck);
    valid = 1; pc = p; is_cond = c; taken = tk; target = tg;
    ex_valid = 0; pred_taken = ptk; pred_addr = pad; chkp = ck;
  endtask

  task automatic cleanup();
    idle();
    flush = 1; uready = 1;
    step();
    idle();
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_stall"}, 64'(stall), 64'd0);
    chk({n, "_rv"},    64'(rv),    64'd0);
    chk({n, "_rpc"},   rpc,        64'd0);
    chk({n, "_rchkp"}, 64'(rchkp), 64'd0);
    chk({n, "_uv"},    64'(uv),    64'd0);
    chk({n, "_upc"},   upc,        64'd0);
    chk({n, "_utgt"},  utgt,       64'd0);
    chk({n, "_utk"},   64'(utaken), 64'd0);
    chk({n, "_ucond"}, 64'(ucond), 64'd0);
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    chk_reset("reset");
    rst = 0;
    step();

    vt[0] = mk("ok_taken", 1, 64'h1000, 1, 1, 64'h1040, 0, 1, 64'h1040,
               0, 0, 0, 0, 0, 1, 64'h1000, 64'h1040, 1, 1);
    vt[1] = mk("dir_mis", 1, 64'h2000, 1, 0, 64'h2040, 0, 1, 64'h2040,
               2, 0, 1, 64'h2004, 2, 1, 64'h2000, 64'h2040, 0, 1);
    vt[2] = mk("jalr_mis", 1, 64'h2800, 0, 1, 64'h3000, 0, 1, 64'h3008,
               1, 0, 1, 64'h3000, 1, 1, 64'h2800, 64'h3000, 1, 0);
    vt[3] = mk("ok_nt", 1, 64'h4000, 1, 0, 64'h4100, 0, 0, 64'h0,
               0, 0, 0, 0, 0, 1, 64'h4000, 64'h4100, 0, 1);
    vt[4] = mk("nt_pred", 1, 64'h5000, 1, 1, 64'h5200, 0, 0, 64'h0,
               3, 0, 1, 64'h5200, 3, 1, 64'h5000, 64'h5200, 1, 1);
    vt[5] = mk("wrap", 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h10, 0, 1,
               64'h10, 1, 0, 1, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC,
               64'h10, 0, 1);
    vt[6] = mk("exc", 1, 64'h6000, 1, 0, 64'h6100, 1, 1, 64'h6100,
               2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[7] = mk("novalid", 0, 64'h7000, 1, 0, 64'h7100, 0, 1, 64'h7100,
               2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[8] = mk("flush_acc", 1, 64'h8000, 1, 0, 64'h8040, 0, 1, 64'h8040,
               1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[9] = mk("nt_addr", 1, 64'h9000, 1, 0, 64'h9100, 0, 0, 64'h9999,
               0, 0, 0, 0, 0, 1, 64'h9000, 64'h9100, 0, 1);

    for (int i = 0; i < 10; i++) begin
      idle();
      valid = vt[i].valid; pc = vt[i].pc; is_cond = vt[i].cond;
      taken = vt[i].taken; target = vt[i].target;
      ex_valid = vt[i].exv; pred_taken = vt[i].pt;
      pred_addr = vt[i].pa; chkp = vt[i].chkp; flush = vt[i].flush;
      step();
      idle();
      chk({vt[i].name, "_rv"}, 64'(rv), 64'(vt[i].e_rv));
      if (vt[i].e_rv) begin
        chk({vt[i].name, "_rpc"}, rpc, vt[i].e_rpc);
        chk({vt[i].name, "_rchkp"}, 64'(rchkp), 64'(vt[i].e_chkp));
      end
      chk({vt[i].name, "_uv"}, 64'(uv), 64'(vt[i].e_uv));
      if (vt[i].e_uv) begin
        chk({vt[i].name, "_upc"}, upc, vt[i].e_upc);
        chk({vt[i].name, "_utgt"}, utgt, vt[i].e_utgt);
        chk({vt[i].name, "_utk"}, 64'(utaken), 64'(vt[i].e_utk));
        chk({vt[i].name, "_ucond"}, 64'(ucond), 64'(vt[i].e_ucond));
      end
      cleanup();
      chk({vt[i].name, "_clean_rv"}, 64'(rv), 64'd0);
      chk({vt[i].name, "_clean_uv"}, 64'(uv), 64'd0);
    end

    // Held redirect, ready pulse to DRAIN, drop in DRAIN, flush to IDLE.
    br(64'h2000, 1, 0, 64'h2040, 1, 64'h2040, 2);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("hold_rv", 64'(rv), 64'd1);
      chk("hold_rpc", rpc, 64'h2004);
      chk("hold_chkp", 64'(rchkp), 64'd2);
      step();
    end
    rready = 1;
    step();
    rready = 0;
    chk("drain_rv", 64'(rv), 64'd0);
    br(64'h7000, 1, 1, 64'h7040, 1, 64'h7040, 0);
    step();
    idle();
    chk("drain_drop_rv", 64'(rv), 64'd0);
    chk("drain_head", upc, 64'h2000);
    flush = 1;
    step();
    flush = 0;
    uready = 1;
    step();
    uready = 0;
    chk("drain_no_push", 64'(uv), 64'd0);
    br(64'h7100, 1, 1, 64'h7140, 1, 64'h7140, 0);
    step();
    idle();
    chk("post_flush_uv", 64'(uv), 64'd1);
    chk("post_flush_upc", upc, 64'h7100);
    cleanup();

    // Back-to-back: second branch after a JALR mispredict is wrong-path.
    br(64'h2800, 0, 1, 64'h3000, 1, 64'h3008, 1);
    step();
    chk("jalr_rv", 64'(rv), 64'd1);
    chk("jalr_rpc", rpc, 64'h3000);
    br(64'h3100, 1, 1, 64'h3140, 1, 64'h3140, 3);
    step();
    idle();
    chk("b2b_rv", 64'(rv), 64'd1);
    chk("b2b_rpc", rpc, 64'h3000);
    chk("b2b_chkp", 64'(rchkp), 64'd1);
    uready = 1;
    step();
    chk("b2b_no_push", 64'(uv), 64'd0);
    cleanup();

    // Fill the queue, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      br(64'hA000 + 64'(16 * i), 1, 1, 64'hA800, 1, 64'hA800, 0);
      step();
      chk("fill_stall", 64'(stall), (i == 3) ? 64'd1 : 64'd0);
    end
    br(64'hA040, 1, 1, 64'hA800, 1, 64'hA800, 0);
    uready = 1;
    step();
    idle();
    chk("full_pp_stall", 64'(stall), 64'd1);
    chk("full_pp_head", upc, 64'hA010);
    uready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("order_upc", upc, 64'hA010 + 64'(16 * i));
      step();
      if (i == 0) chk("stall_fall", 64'(stall), 64'd0);
    end
    chk("drained_uv", 64'(uv), 64'd0);
    idle();

    // Flush and ready together in REDIRECT: flush wins, queue kept.
    br(64'hB000, 1, 1, 64'hB040, 1, 64'hB040, 0);
    step();
    br(64'hB100, 1, 0, 64'hB140, 1, 64'hB140, 3);
    step();
    idle();
    chk("col_rv", 64'(rv), 64'd1);
    chk("col_rpc", rpc, 64'hB104);
    flush = 1; rready = 1;
    step();
    idle();
    chk("col_rv_after", 64'(rv), 64'd0);
    br(64'hB200, 1, 1, 64'hB240, 1, 64'hB240, 0);
    step();
    idle();
    uready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("col_order", upc, 64'hB000 + 64'(256 * i));
      step();
    end
    chk("col_empty", 64'(uv), 64'd0);
    idle();

    // Reset in the middle of a pending redirect with queued entries.
    br(64'hC000, 1, 1, 64'hC040, 1, 64'hC040, 0);
    step();
    br(64'hC100, 1, 0, 64'hC140, 1, 64'hC140, 2);
    step();
    idle();
    rst = 1;
    step();
    chk_reset("midrst");
    rst = 0;
    step();

`ifdef BRU_PERF_CNT_EN
    uready = 1;
    for (int i = 0; i < 5; i++) begin
      br(64'hD000 + 64'(16 * i), 1, 1, 64'hD800, 1, 64'hD800, 0);
      step();
    end
    br(64'hD100, 1, 0, 64'hD200, 1, 64'hD200, 1);
    step();
    br(64'hD110, 1, 1, 64'hD200, 1, 64'hD200, 0);
    step();
    valid = 0; flush = 1;
    step();
    flush = 0;
    br(64'hD120, 1, 1, 64'hD300, 0, 64'h0, 1);
    step();
    valid = 0; flush = 1;
    step();
    flush = 0;
    br(64'hD130, 0, 1, 64'hD400, 1, 64'hD404, 1);
    step();
    valid = 0; flush = 1;
    step();
    flush = 0;
    br(64'hD140, 1, 0, 64'hD500, 1, 64'hD500, 0);
    ex_valid = 1;
    step();
    idle();
    chk("perf_branches", 64'(perf_br), 64'd8);
    chk("perf_mispred", 64'(perf_mp), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
